// File: rtl/bitwise_feeder.sv
// bitwise_feeder: takes whole words over valid/ready and drives the bitwise
// shift register. Each word goes out as an MSB-first serial stream on d/en,
// or as a single parallel-load pulse on load_en/load.
module bitwise_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             in_ready,
  output logic             d,
  output logic             en,
  output logic             load_en,
  output logic [WIDTH-1:0] load,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  // Unused when GAP is 0; clamped so the subtraction never wraps.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             done_n;
  logic             accept;

  // in_ready is only ever high while in IDLE, so it alone qualifies acceptance.
  assign accept = in_valid & in_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Next-state, shift register and counter update.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          sr_n      = in_data;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          state_n   = in_mode ? S_LOAD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_n      = {sr[WIDTH-2:0], 1'b0};
        bit_cnt_n = bit_cnt + BIT_W'(1);
        gap_cnt_n = '0;
        if (bit_cnt == BIT_LAST) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (HAS_GAP) begin
          state_n = S_GAP;
        end else begin
          state_n = S_SHIFT;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = S_SHIFT;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      S_LOAD: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so each one lines up
  // with the cycle that state is active; d and load are forced to 0 when
  // their qualifier is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b0;
      d        <= 1'b0;
      en       <= 1'b0;
      load_en  <= 1'b0;
      load     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_n == S_IDLE);
      en       <= (state_n == S_SHIFT);
      d        <= (state_n == S_SHIFT) & sr_n[WIDTH-1];
      load_en  <= (state_n == S_LOAD);
      load     <= (state_n == S_LOAD) ? sr_n : '0;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: doc/bitwise_feeder.md
# bitwise_feeder

Upstream driver for the `bitwise` shift register. Accepts whole words over a valid/ready handshake and turns each into either a serial MSB-first bit stream on `d`/`en`, or a single parallel-load pulse on `load_en`/`load`. Its outputs connect directly to the matching `bitwise` inputs. The block is a single-clock FSM with bit and gap counters. All outputs are registered.

## Interface
- `WIDTH`, default 8: word width; must match the `load` width of the downstream register; must be ≥ 2.
- `GAP`, default 0: idle cycles inserted between consecutive serial bits; legal range 0–15.
- `clk`  in  1  — clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — upstream word available.
- `in_data`  in  WIDTH  — word to send.
- `in_mode`  in  1  — 0 = serial shift, 1 = parallel load.
- `in_ready`  out  1  — block can accept a word this cycle.
- `d`  out  1  — serial data bit to the shift register.
- `en`  out  1  — shift enable; qualifies `d`.
- `load_en`  out  1  — parallel-load strobe.
- `load`  out  WIDTH  — parallel-load value.
- `busy`  out  1  — a transfer is in progress.
- `done`  out  1  — one-cycle pulse when a transfer completes.

## Operation
- **Reset values.** With `reset`=1 at a rising edge: state = IDLE, and `d`, `en`, `load_en`, `busy`, `done` = 0, `load` = 0. `in_ready` is 0 in the reset cycle and 1 in the first cycle after reset deasserts.
- **Handshake.** A word is accepted when `in_valid` & `in_ready` are both 1 at a rising edge.
  - `in_ready` = 1 only in IDLE.
  - The block captures `in_data` and `in_mode` into an internal shift register `sr` and a mode flag on acceptance.
  - `in_valid` while not ready is ignored. The source must hold its word until accepted.
- **FSM states.**
  - IDLE → SHIFT on accept with `in_mode`=0.
  - IDLE → LOAD on accept with `in_mode`=1.
  - LOAD → IDLE after 1 cycle.
  - SHIFT → GAP after a non-final bit when `GAP` > 0.
  - SHIFT → SHIFT after a non-final bit when `GAP` = 0.
  - SHIFT → IDLE after the final bit.
  - GAP → SHIFT when the gap counter reaches `GAP`-1.
- **SHIFT.** For one cycle per bit: `en`=1 and `d`=`sr[WIDTH-1]`. Then `sr` shifts left by one, filling with 0, and the bit counter increments. The counter is `$clog2(WIDTH)` bits wide and counts 0 to `WIDTH`-1. The final bit is the one sent when the counter equals `WIDTH`-1.
- **GAP.** `en`=0 and `d`=0. There is no gap after the final bit.
- **LOAD.** For exactly one cycle: `load_en`=1 and `load` = the captured word; `en`=0.
- **Idle output values.** `load` = 0 whenever `load_en`=0. `d` = 0 whenever `en`=0. `en` and `load_en` are never both 1.
- **Completion.** `busy` = 1 in SHIFT, GAP and LOAD; otherwise 0. `done` = 1 in the first IDLE cycle after SHIFT or LOAD finishes. `in_ready` is also 1 in that cycle, so a new word can be accepted in the same cycle as `done`.
- **Reset mid-transfer.** The transfer is aborted and the remaining bits are dropped. No `done` pulse is produced for it. Outputs take their reset values at that edge.
- **in_mode.** Sampled only at acceptance. Changes at any other time have no effect.

## Timing
- Accept at edge T. The first serial bit (or the `load_en` pulse) is visible in the cycle after T.
- **Serial mode.** Bit k (k = 0 is the MSB) has `en`=1 in cycle T+1+k·(GAP+1). `done` is high in cycle T+1+(WIDTH-1)·(GAP+1)+1.
- **Serial throughput.** With back-to-back valid words, one word every 1+WIDTH+(WIDTH-1)·GAP cycles. For `WIDTH`=8 and `GAP`=0 that is 9 cycles.
- **Load mode.** `load_en` is high in cycle T+1 and `done` in cycle T+2. Throughput is one word every 2 cycles.
- **Downstream compatibility.** The downstream register must see `en`=0 between transfers. The block guarantees this.

## Test plan
- **Serial, GAP=0.** Reset, then accept 0xA5 with mode 0 at cycle T.
  - `d` must be 1,0,1,0,0,1,0,1 on cycles T+1..T+8, with `en`=1 throughout.
  - `done`=1 and `en`=0 at T+9.
  - The downstream `q` must end at 0xA5.
- **Load.** Accept 0x3C with mode 1 at T.
  - `load_en`=1 and `load`=0x3C at T+1 only.
  - `en`=0 throughout.
  - `done`=1 at T+2.
- **Serial, GAP=2.** Accept 0x81.
  - `en` pulses at T+1, T+4, …, T+22.
  - `d`=1 only at T+1 and T+22.
  - `done`=1 at T+23.
- **Back-to-back.** Hold `in_valid` with 0xFF then 0x00, both mode 0.
  - The second word is accepted in the `done` cycle of the first (T+9).
  - The second word's bits appear at T+10..T+17.
  - `in_ready`=0 from T+1 to T+8.
- **Reset mid-operation.** Assert `reset` at T+4 during a 0xF0 shift.
  - `en`, `d`, `busy` and `done` = 0 from the next cycle on, with no `done` pulse.
  - After release, accepting 0x0F serialises correctly.
- **Ignored input while busy.** Change `in_valid`, `in_data` and `in_mode` while `busy`=1. The stream must be unaffected and `in_ready` must stay 0.
